// File: rtl/drive_cmd_if.sv
// ---------------------------------------------------------------------------
// drive_cmd_if
// Bundles the requester strobes, the obstacle level and the motor-side
// outputs of drive_cmd_arbiter so the block can be wired up as one port.
//   rc_valid/rc_cmd  : remote-link frame strobe and 8-bit command code
//   au_valid/au_cmd  : autonomous request strobe and 8-bit command code
//   obstacle         : 1 = forward path blocked (synchronous level)
//   cmd_out          : command code to the motor-bridge driver
//   duty             : PWM duty word
//   owner            : 0 = none, 1 = remote, 2 = auto
//   dwell            : 1 while the reversal dwell is running
//   cmd_err          : one-cycle pulse on an illegal command code
// master drives the requests (environment), slave is the arbiter.
// ---------------------------------------------------------------------------
interface drive_cmd_if;
  logic       rc_valid;
  logic [7:0] rc_cmd;
  logic       au_valid;
  logic [7:0] au_cmd;
  logic       obstacle;
  logic [7:0] cmd_out;
  logic [7:0] duty;
  logic [1:0] owner;
  logic       dwell;
  logic       cmd_err;

  modport master (
    output rc_valid, rc_cmd, au_valid, au_cmd, obstacle,
    input  cmd_out, duty, owner, dwell, cmd_err
  );

  modport slave (
    input  rc_valid, rc_cmd, au_valid, au_cmd, obstacle,
    output cmd_out, duty, owner, dwell, cmd_err
  );
endinterface

// File: rtl/drive_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// drive_cmd_arbiter
// Sequencer in front of the motor-bridge driver. Arbitrates drive commands
// from the remote link and the autonomous requester, blocks forward motion
// on an obstacle, drops remote ownership after a silence timeout, inserts a
// STOP dwell on FWD<->BACK reversal and produces the PWM duty word.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : drive_cmd_if.slave (requests in, cmd_out/duty/owner/dwell/
//            cmd_err out)
//
// Build option:
//   DRIVE_RAMP_EN defined   : duty starts at DUTY_START on each new motion
//                             command and ramps by RAMP_STEP every RAMP_DIV
//                             cycles, saturating at DUTY_MAX.
//   DRIVE_RAMP_EN undefined : duty jumps straight to DUTY_MAX and holds.
//
// Command codes: FWD=24, BACK=82, LEFT=8, RIGHT=90, STOP=28.
// ---------------------------------------------------------------------------
module drive_cmd_arbiter #(
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter int         DWELL_CYC   = 5_000_000,
  parameter logic [7:0] DUTY_START  = 8'd64,
  parameter logic [7:0] DUTY_MAX    = 8'd255,
  parameter int         RAMP_DIV    = 500_000,
  parameter logic [7:0] RAMP_STEP   = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  drive_cmd_if.slave  bus
);

  localparam logic [7:0] C_FWD   = 8'd24;
  localparam logic [7:0] C_BACK  = 8'd82;
  localparam logic [7:0] C_LEFT  = 8'd8;
  localparam logic [7:0] C_RIGHT = 8'd90;
  localparam logic [7:0] C_STOP  = 8'd28;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RC   = 2'd1;
  localparam logic [1:0] OWN_AU   = 2'd2;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(DWELL_CYC + 1);

  // Elaboration-time sanity check of the configuration.
  if (TIMEOUT_CYC < 1 || DWELL_CYC < 1 || RAMP_DIV < 1 || RAMP_STEP == 8'd0 ||
      DUTY_START > DUTY_MAX) begin : g_cfg_check
    $error("drive_cmd_arbiter: illegal parameter set");
  end

`ifdef DRIVE_RAMP_EN
  localparam int         PW        = $clog2(RAMP_DIV + 1);
  localparam logic [7:0] DUTY_LOAD = DUTY_START;
`else
  localparam logic [7:0] DUTY_LOAD = DUTY_MAX;
`endif

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DWELL} state_t;

  function automatic logic is_legal(input logic [7:0] c);
    return (c == C_FWD) || (c == C_BACK) || (c == C_LEFT) ||
           (c == C_RIGHT) || (c == C_STOP);
  endfunction

  function automatic logic is_reversal(input logic [7:0] from, input logic [7:0] to);
    return ((from == C_FWD) && (to == C_BACK)) || ((from == C_BACK) && (to == C_FWD));
  endfunction

`ifdef DRIVE_RAMP_EN
  // 9-bit add so a step past the ceiling saturates instead of wrapping.
  function automatic logic [7:0] ramp_sat(input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, d} + {1'b0, RAMP_STEP};
    return (s > {1'b0, DUTY_MAX}) ? DUTY_MAX : s[7:0];
  endfunction
`endif

  // ---- stage p0: arbitration / latched requests --------------------------
  logic [7:0]    rc_cmd_p0;
  logic [7:0]    au_cmd_p0;
  logic [1:0]    owner_p0;
  logic          au_seen_p0;
  logic [TW-1:0] tmo_cnt_p0;
  logic          cmd_err_p0;

  logic rc_ok;
  logic au_ok;
  logic timeout;

  assign rc_ok   = bus.rc_valid && is_legal(bus.rc_cmd);
  assign au_ok   = bus.au_valid && is_legal(bus.au_cmd);
  // A fresh remote frame in the expiry cycle wins over the timeout.
  assign timeout = (owner_p0 == OWN_RC) && (tmo_cnt_p0 == '0) && !rc_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_cmd_p0  <= C_STOP;
      au_cmd_p0  <= C_STOP;
      owner_p0   <= OWN_NONE;
      au_seen_p0 <= 1'b0;
      tmo_cnt_p0 <= '0;
      cmd_err_p0 <= 1'b0;
    end else begin
      cmd_err_p0 <= (bus.rc_valid && !is_legal(bus.rc_cmd)) ||
                    (bus.au_valid && !is_legal(bus.au_cmd));
      if (rc_ok) begin
        rc_cmd_p0  <= bus.rc_cmd;
        owner_p0   <= OWN_RC;
        tmo_cnt_p0 <= TW'(TIMEOUT_CYC - 1);
      end else if (timeout) begin
        rc_cmd_p0 <= C_STOP;
        owner_p0  <= (au_seen_p0 || au_ok) ? OWN_AU : OWN_NONE;
      end else begin
        if ((owner_p0 == OWN_RC) && (tmo_cnt_p0 != '0))
          tmo_cnt_p0 <= tmo_cnt_p0 - TW'(1);
        if (au_ok && (owner_p0 != OWN_RC))
          owner_p0 <= OWN_AU;
      end
      // Auto requests are always latched, even while remote owns the drive,
      // so a remote timeout can fall back to the most recent one.
      if (au_ok)
        au_cmd_p0 <= bus.au_cmd;
      au_seen_p0 <= timeout ? 1'b0 : (au_seen_p0 | au_ok);
    end
  end

  logic [7:0] target;

  always_comb begin
    target = C_STOP;
    case (owner_p0)
      OWN_RC:  target = rc_cmd_p0;
      OWN_AU:  target = au_cmd_p0;
      default: target = C_STOP;
    endcase
    if (bus.obstacle && (target == C_FWD))
      target = C_STOP;
  end

  // ---- stage p1: motion sequencer / outputs ------------------------------
  state_t        state_p1, state_nxt;
  logic [7:0]    cmd_p1, cmd_nxt;
  logic [7:0]    duty_p1, duty_nxt;
  logic          dwell_p1, dwell_nxt;
  logic [DW-1:0] dcnt_p1, dcnt_nxt;
`ifdef DRIVE_RAMP_EN
  logic [PW-1:0] presc_p1, presc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= ST_STOP;
    else        state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    cmd_nxt   = cmd_p1;
    duty_nxt  = duty_p1;
    dwell_nxt = dwell_p1;
    dcnt_nxt  = dcnt_p1;
`ifdef DRIVE_RAMP_EN
    presc_nxt = presc_p1;
`endif
    case (state_p1)
      ST_STOP: begin
        if (target != C_STOP) begin
          state_nxt = ST_RUN;
          cmd_nxt   = target;
          duty_nxt  = DUTY_LOAD;
        end
      end
      ST_RUN: begin
        if (target == cmd_p1) begin
`ifdef DRIVE_RAMP_EN
          if (presc_p1 == PW'(RAMP_DIV - 1)) begin
            presc_nxt = '0;
            duty_nxt  = ramp_sat(duty_p1);
          end else begin
            presc_nxt = presc_p1 + PW'(1);
          end
`endif
        end else if (target == C_STOP) begin
          state_nxt = ST_STOP;
          cmd_nxt   = C_STOP;
          duty_nxt  = 8'd0;
        end else if (is_reversal(cmd_p1, target)) begin
          state_nxt = ST_DWELL;
          cmd_nxt   = C_STOP;
          duty_nxt  = 8'd0;
          dwell_nxt = 1'b1;
          dcnt_nxt  = DW'(DWELL_CYC - 1);
        end else begin
          cmd_nxt  = target;
          duty_nxt = DUTY_LOAD;
        end
      end
      ST_DWELL: begin
        // Target changes during the dwell only matter at its exit.
        if (dcnt_p1 == '0) begin
          dwell_nxt = 1'b0;
          if (target == C_STOP) begin
            state_nxt = ST_STOP;
          end else begin
            state_nxt = ST_RUN;
            cmd_nxt   = target;
            duty_nxt  = DUTY_LOAD;
          end
        end else begin
          dcnt_nxt = dcnt_p1 - DW'(1);
        end
      end
      default: state_nxt = ST_STOP;
    endcase
`ifdef DRIVE_RAMP_EN
    // Every new command restarts the ramp period from zero.
    if (cmd_nxt != cmd_p1)
      presc_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_p1   <= C_STOP;
      duty_p1  <= 8'd0;
      dwell_p1 <= 1'b0;
      dcnt_p1  <= '0;
`ifdef DRIVE_RAMP_EN
      presc_p1 <= '0;
`endif
    end else begin
      cmd_p1   <= cmd_nxt;
      duty_p1  <= duty_nxt;
      dwell_p1 <= dwell_nxt;
      dcnt_p1  <= dcnt_nxt;
`ifdef DRIVE_RAMP_EN
      presc_p1 <= presc_nxt;
`endif
    end
  end

  assign bus.cmd_out = cmd_p1;
  assign bus.duty    = duty_p1;
  assign bus.owner   = owner_p0;
  assign bus.dwell   = dwell_p1;
  assign bus.cmd_err = cmd_err_p0;

endmodule
